// File: rtl/unidad_carga_almacen_pkg.sv
// Shared constants for the load/store unit: access size codes and FSM state encoding.
package paquete_mem;

    localparam logic [1:0] TAM_BYTE    = 2'b00;
    localparam logic [1:0] TAM_MEDIA   = 2'b01;
    localparam logic [1:0] TAM_PALABRA = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEER = 3'd1,
        CAPT = 3'd2,
        ESCR = 3'd3,
        RESP = 3'd4
    } estado_t;

endpackage

// File: rtl/unidad_carga_almacen_alineador.sv
// Lane logic: extracts/extends load lanes, merges sub-word store data into a read word,
// and flags misaligned or illegal access sizes.
module alineador_bytes
    import paquete_mem::*;
(
    input  logic [1:0]  desp,
    input  logic [1:0]  tam,
    input  logic        sign,
    input  logic [31:0] leido,
    input  logic [31:0] dato,
    output logic [31:0] carga,
    output logic [31:0] fusion,
    output logic        desalineado
);

    logic [7:0]  byte_sel;
    logic [15:0] media_sel;
    logic [31:0] dato_rep;
    logic [3:0]  carril;

    always_comb begin
        byte_sel    = leido[{desp, 3'b000} +: 8];
        media_sel   = desp[1] ? leido[31:16] : leido[15:0];
        carga       = leido;
        dato_rep    = dato;
        desalineado = 1'b0;
        case (tam)
            TAM_BYTE: begin
                carga    = {{24{sign & byte_sel[7]}}, byte_sel};
                dato_rep = {4{dato[7:0]}};
            end
            TAM_MEDIA: begin
                carga       = {{16{sign & media_sel[15]}}, media_sel};
                dato_rep    = {2{dato[15:0]}};
                desalineado = desp[0];
            end
            TAM_PALABRA: desalineado = (desp != 2'b00);
            default:     desalineado = 1'b1;
        endcase
    end

    // Store data is replicated across lanes, so each lane only chooses new vs. preserved byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_carril
            localparam logic [1:0] CARRIL = 2'(gi);
            assign carril[gi] = (tam == TAM_PALABRA)
                              | ((tam == TAM_BYTE)  & (desp == CARRIL))
                              | ((tam == TAM_MEDIA) & (desp[1] == CARRIL[1]));
            assign fusion[8*gi+7:8*gi] = carril[gi] ? dato_rep[8*gi+7:8*gi] : leido[8*gi+7:8*gi];
        end
    endgenerate

endmodule

// File: rtl/unidad_carga_almacen.sv
// Load/store initiator for memoria_datos: byte/half/word requests, read-modify-write for
// sub-word stores, sign/zero-extended loads, one-cycle response pulse.
module unidad_carga_almacen
    import paquete_mem::*;
#(
    parameter int ANCHO_DIRM = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_escr,
    input  logic [1:0]            req_tam,
    input  logic                  req_sign,
    input  logic [ANCHO_DIRM+1:0] req_direc,
    input  logic [31:0]           req_dato,
    output logic                  resp_valid,
    output logic [31:0]           resp_dato,
    output logic                  resp_err,
    output logic                  EscrMem,
    output logic                  LeerMem,
    output logic [ANCHO_DIRM-1:0] Direc,
    output logic [31:0]           Datain,
    input  logic [31:0]           Dataout
);

    estado_t               estado_reg, estado_next;
    logic                  escr_reg, sign_reg, resp_err_reg;
    logic [1:0]            tam_reg;
    logic [ANCHO_DIRM+1:0] direc_reg;
    logic [31:0]           dato_reg, datain_reg, resp_dato_reg;

    logic        aceptar, libre;
    logic [1:0]  al_desp, al_tam;
    logic        al_sign;
    logic [31:0] carga, fusion;
    logic        desalineado;

    assign libre   = (estado_reg == IDLE);
    assign aceptar = req_valid & req_ready;

    // While idle the aligner judges the incoming request; afterwards it works on the latched one.
    always_comb begin
        al_desp = libre ? req_direc[1:0] : direc_reg[1:0];
        al_tam  = libre ? req_tam        : tam_reg;
        al_sign = libre ? req_sign       : sign_reg;
    end

    alineador_bytes u_alineador (
        .desp        (al_desp),
        .tam         (al_tam),
        .sign        (al_sign),
        .leido       (Dataout),
        .dato        (dato_reg),
        .carga       (carga),
        .fusion      (fusion),
        .desalineado (desalineado)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) estado_reg <= IDLE;
        else        estado_reg <= estado_next;
    end

    always_comb begin
        estado_next = estado_reg;
        case (estado_reg)
            IDLE: if (aceptar) begin
                if (desalineado)                             estado_next = RESP;
                else if (req_escr && req_tam == TAM_PALABRA) estado_next = ESCR;
                else                                         estado_next = LEER;
            end
            LEER:    estado_next = CAPT;
            CAPT:    estado_next = escr_reg ? ESCR : RESP;
            ESCR:    estado_next = RESP;
            RESP:    estado_next = IDLE;
            default: estado_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = libre & rst_n;
        LeerMem    = ((estado_reg == LEER) | (estado_reg == CAPT)) & rst_n;
        EscrMem    = (estado_reg == ESCR) & rst_n;
        resp_valid = (estado_reg == RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            escr_reg      <= 1'b0;
            sign_reg      <= 1'b0;
            tam_reg       <= 2'b00;
            direc_reg     <= '0;
            dato_reg      <= '0;
            datain_reg    <= '0;
            resp_dato_reg <= '0;
            resp_err_reg  <= 1'b0;
        end else begin
            if (aceptar) begin
                escr_reg  <= req_escr;
                sign_reg  <= req_sign;
                tam_reg   <= req_tam;
                direc_reg <= req_direc;
                dato_reg  <= req_dato;
                if (req_escr && req_tam == TAM_PALABRA) datain_reg <= req_dato;
                if (desalineado) begin
                    resp_dato_reg <= '0;
                    resp_err_reg  <= 1'b1;
                end
            end
            if (estado_reg == CAPT) begin
                if (escr_reg) begin
                    datain_reg <= fusion;
                end else begin
                    resp_dato_reg <= carga;
                    resp_err_reg  <= 1'b0;
                end
            end
            if (estado_reg == ESCR) begin
                resp_dato_reg <= '0;
                resp_err_reg  <= 1'b0;
            end
        end
    end

    assign Direc     = direc_reg[ANCHO_DIRM+1:2];
    assign Datain    = datain_reg;
    assign resp_dato = resp_dato_reg;
    assign resp_err  = resp_err_reg;

endmodule
